// File: rtl/iomem_gpio_timer_pkg.sv
// Shared constants for the iomem GPIO/timer peripheral: register offsets,
// CTRL bit positions and the default window base.
package iomem_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0300_0000;

   localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
   localparam logic [7:0] OFF_GPIO_OE  = 8'h04;
   localparam logic [7:0] OFF_GPIO_IN  = 8'h08;
   localparam logic [7:0] OFF_CTRL     = 8'h0C;
   localparam logic [7:0] OFF_LOAD     = 8'h10;
   localparam logic [7:0] OFF_COUNT    = 8'h14;
   localparam logic [7:0] OFF_STATUS   = 8'h18;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // Expands the four byte strobes into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/iomem_gpio_timer_if.sv
// picosoc iomem bus bundle; the core side is the master, peripherals are slaves.
interface iomem_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );
endinterface

// File: rtl/iomem_gpio_timer_sync_ff.sv
// Multi-flop synchronizer for asynchronous pad inputs; output is the last stage.
module sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] stg_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stg_q <= '0;
      else       stg_q <= {stg_q[STAGES-2:0], d_i};
   end

   assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/iomem_gpio_timer.sv
// iomem slave with a GPIO bank and a 32-bit down-counting timer driving a
// level interrupt. Silent outside its 256-byte window.
module iomem_gpio_timer
   import iomem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          GPIO_W      = 16,
   parameter int          SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   iomem_if.slave            bus,
   input  logic [GPIO_W-1:0] gpio_in_i,
   output logic [GPIO_W-1:0] gpio_out_o,
   output logic [GPIO_W-1:0] gpio_oe_o,
   output logic              timer_irq_o
);

   logic [GPIO_W-1:0] gpio_sync;

   sync_ff #(.WIDTH(GPIO_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (gpio_in_i),
      .q_o   (gpio_sync)
   );

   logic              ready_q, gap_q;
   logic [31:0]       rdata_q, rdata_d;
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] gpio_oe_q, gpio_oe_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [31:0]       load_q, load_d;
   logic [31:0]       count_q, count_d;
   logic              expired_q, expired_d;
   logic              irq_q;

   logic        in_win, accept, wr;
   logic [7:0]  off;
   logic [31:0] bmask, rd_data;
   logic        hit;

   // gap_q keeps one idle cycle after each ready pulse so a held valid
   // cannot be acknowledged twice.
   assign in_win = (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign accept = bus.iomem_valid && in_win && !ready_q && !gap_q;
   assign wr     = accept && (bus.iomem_wstrb != 4'b0000);
   assign off    = bus.iomem_addr[7:0];
   assign bmask  = strb_mask(bus.iomem_wstrb);

   always_comb begin
      rd_data = '0;
      case (off)
         OFF_GPIO_OUT: rd_data = 32'(gpio_out_q);
         OFF_GPIO_OE:  rd_data = 32'(gpio_oe_q);
         OFF_GPIO_IN:  rd_data = 32'(gpio_sync);
         OFF_CTRL:     rd_data = {29'b0, ctrl_q};
         OFF_LOAD:     rd_data = load_q;
         OFF_COUNT:    rd_data = count_q;
         OFF_STATUS:   rd_data = {31'b0, expired_q};
         default:      rd_data = '0;
      endcase
      rdata_d = accept ? rd_data : '0;
   end

   always_comb begin
      gpio_out_d = gpio_out_q;
      gpio_oe_d  = gpio_oe_q;
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      count_d    = count_q;
      expired_d  = expired_q;
      hit        = 1'b0;

      if (ctrl_q[CTRL_EN]) begin
         if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
         end else begin
            hit = 1'b1;
            if (ctrl_q[CTRL_AUTO]) count_d = load_q;
            else                   ctrl_d[CTRL_EN] = 1'b0;
         end
      end

      // Bus writes are applied after the timer step so they take priority.
      if (wr) begin
         case (off)
            OFF_GPIO_OUT: gpio_out_d = (gpio_out_q & ~bmask[GPIO_W-1:0]) |
                                       (bus.iomem_wdata[GPIO_W-1:0] & bmask[GPIO_W-1:0]);
            OFF_GPIO_OE:  gpio_oe_d  = (gpio_oe_q & ~bmask[GPIO_W-1:0]) |
                                       (bus.iomem_wdata[GPIO_W-1:0] & bmask[GPIO_W-1:0]);
            OFF_CTRL:     if (bus.iomem_wstrb[0]) ctrl_d = bus.iomem_wdata[2:0];
            OFF_LOAD:     load_d  = (load_q & ~bmask) | (bus.iomem_wdata & bmask);
            OFF_COUNT:    count_d = (count_q & ~bmask) | (bus.iomem_wdata & bmask);
            OFF_STATUS:   if (bus.iomem_wstrb[0] && bus.iomem_wdata[0]) expired_d = 1'b0;
            default:      ;
         endcase
      end

      if (hit) expired_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q    <= 1'b0;
         gap_q      <= 1'b0;
         rdata_q    <= '0;
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
         ctrl_q     <= '0;
         load_q     <= '0;
         count_q    <= '0;
         expired_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         ready_q    <= accept;
         gap_q      <= ready_q;
         rdata_q    <= rdata_d;
         gpio_out_q <= gpio_out_d;
         gpio_oe_q  <= gpio_oe_d;
         ctrl_q     <= ctrl_d;
         load_q     <= load_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         irq_q      <= expired_q & ctrl_q[CTRL_IRQ_EN];
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign gpio_out_o      = gpio_out_q;
   assign gpio_oe_o       = gpio_oe_q;
   assign timer_irq_o     = irq_q;

endmodule

// File: tb/tb_iomem_gpio_timer.sv
// Scoreboard bench: drivers push expected read data, a negedge monitor pops
// and compares on every ready pulse. Register/timer behaviour comes from a
// plain-arithmetic reference model.
module tb_iomem_gpio_timer;
   import iomem_pkg::*;

   localparam int          GW    = 16;
   localparam logic [31:0] GMASK = 32'h0000_FFFF;
   localparam logic [31:0] BASE  = 32'h0300_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [GW-1:0] gpio_in, gpio_out, gpio_oe;
   logic          irq;

   iomem_if bus ();

   iomem_gpio_timer #(.BASE_ADDR(BASE), .GPIO_W(GW), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .gpio_in_i   (gpio_in),
      .gpio_out_o  (gpio_out),
      .gpio_oe_o   (gpio_oe),
      .timer_irq_o (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] ev;
      bit          chk;
      string       nm;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ev);
      checks++;
      if (act !== ev) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, ev);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (!reset && bus.iomem_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.chk) check(mon_e.nm, bus.iomem_rdata, mon_e.ev);
         end
      end
   end

   // Reference model state
   logic [31:0] m_out, m_oe, m_load, m_count;
   logic [2:0]  m_ctrl;
   bit          m_exp;
   logic [31:0] gin_old, gin_new;
   int          gin_edge;

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Value a read returns when issued right after edge n.
   function automatic logic [31:0] model_read(input logic [7:0] o, input int n);
      case (o)
         OFF_GPIO_OUT: return m_out;
         OFF_GPIO_OE:  return m_oe;
         OFF_GPIO_IN:  return (n >= gin_edge + 2) ? gin_new : gin_old;
         OFF_CTRL:     return {29'b0, m_ctrl};
         OFF_LOAD:     return m_load;
         OFF_COUNT:    return m_count;
         OFF_STATUS:   return {31'b0, m_exp};
         default:      return 32'd0;
      endcase
   endfunction

   task automatic model_write(input logic [7:0] o, input logic [3:0] s, input logic [31:0] d);
      case (o)
         OFF_GPIO_OUT: m_out   = bmerge(m_out, d, s) & GMASK;
         OFF_GPIO_OE:  m_oe    = bmerge(m_oe, d, s) & GMASK;
         OFF_CTRL:     if (s[0]) m_ctrl = d[2:0];
         OFF_LOAD:     m_load  = bmerge(m_load, d, s);
         OFF_COUNT:    m_count = bmerge(m_count, d, s);
         OFF_STATUS:   if (s[0] && d[0]) m_exp = 1'b0;
         default:      ;
      endcase
   endtask

   task automatic model_reset();
      m_out = 0; m_oe = 0; m_load = 0; m_count = 0; m_ctrl = 0; m_exp = 0;
   endtask

   // Timer value k edges after enabling with COUNT=c, LOAD=l, auto-reload on.
   function automatic int tf(input int k, input int c, input int l);
      if (k <= c) return c - k;
      return l - ((k - c - 1) % (l + 1));
   endfunction

   task automatic sync_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int t);
      do sync_edge(); while (cyc < t);
   endtask

   // Issues one transaction right now (caller is just past an edge and the
   // bus is idle); commit is the edge that raised ready.
   task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] ev, input bit chk, input string nm,
                       output int commit);
      exp_t e;
      int   n;
      n = cyc;
      e.ev = ev; e.chk = chk; e.nm = nm;
      sbq.push_back(e);
      bus.iomem_addr = a; bus.iomem_wstrb = s; bus.iomem_wdata = d; bus.iomem_valid = 1'b1;
      commit = -1;
      for (int i = 0; i < 8; i++) begin
         sync_edge();
         if (bus.iomem_ready) begin
            commit = cyc;
            break;
         end
      end
      check({nm, "_lat"}, commit, n + 1);
      if (commit < 0) void'(sbq.pop_back());
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0;
      @(posedge clk);
   endtask

   task automatic rd(input logic [7:0] o, input string nm);
      int c;
      sync_edge();
      xfer(BASE | 32'(o), 4'b0, 32'b0, model_read(o, cyc), 1'b1, nm, c);
   endtask

   task automatic wr(input logic [7:0] o, input logic [3:0] s, input logic [31:0] d,
                     input string nm, output int commit);
      sync_edge();
      xfer(BASE | 32'(o), s, d, 32'b0, 1'b0, nm, commit);
      model_write(o, s, d);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int           c, n, e_t, d_t, w_t, x_t, hold, cnt, bad, first;
      logic [7:0]   offs[7];
      logic [7:0]   roffs[10];
      logic [7:0]   o;
      logic [31:0]  d, ev;
      logic [3:0]   s;

      offs  = '{OFF_GPIO_OUT, OFF_GPIO_OE, OFF_GPIO_IN, OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS};
      roffs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'hFC};
      bus.iomem_valid = 0; bus.iomem_wstrb = 0; bus.iomem_addr = 0; bus.iomem_wdata = 0;
      gpio_in = 0;
      model_reset();
      gin_old = 0; gin_new = 0; gin_edge = 0;

      // Reset with toggling inputs
      repeat (6) begin
         @(negedge clk);
         bus.iomem_valid = 1'($urandom);
         bus.iomem_wstrb = 4'($urandom);
         bus.iomem_addr  = BASE | 32'($urandom_range(0, 31) * 4);
         bus.iomem_wdata = $urandom;
         gpio_in         = GW'($urandom);
      end
      @(negedge clk);
      check("rst_ready", 32'(bus.iomem_ready), 0);
      check("rst_rdata", bus.iomem_rdata, 0);
      check("rst_gpio_out", 32'(gpio_out), 0);
      check("rst_gpio_oe", 32'(gpio_oe), 0);
      check("rst_irq", 32'(irq), 0);
      bus.iomem_valid = 0; bus.iomem_wstrb = 0; gpio_in = 0;
      @(posedge clk);
      #1 reset = 0;
      repeat (3) sync_edge();
      foreach (offs[i]) rd(offs[i], "rst_read");

      // GPIO_OUT byte strobe and single-ack on held valid
      wr(OFF_GPIO_OUT, 4'b0001, 32'h0000_A5A5, "wr_out", c);
      sync_edge();
      check("gpio_out_pin", 32'(gpio_out), 32'h0000_00A5);
      rd(OFF_GPIO_OUT, "rd_out");
      begin
         exp_t e;
         sync_edge();
         n = cyc;
         e.ev = model_read(OFF_GPIO_OUT, n); e.chk = 1; e.nm = "held_rd";
         sbq.push_back(e);
         bus.iomem_addr = BASE; bus.iomem_wstrb = 0; bus.iomem_valid = 1;
         cnt = 0; first = -1;
         for (int i = 1; i <= 4; i++) begin
            sync_edge();
            if (bus.iomem_ready) begin
               cnt++;
               if (first < 0) first = cyc;
            end
            if (i == 3) bus.iomem_valid = 0;
         end
         check("held_ready_count", cnt, 1);
         check("held_ready_lat", first, n + 1);
      end

      // Reset in the middle of an access
      sync_edge();
      bus.iomem_addr = BASE | 32'(OFF_GPIO_OE); bus.iomem_wstrb = 0; bus.iomem_valid = 1;
      sync_edge();
      check("mid_ready", 32'(bus.iomem_ready), 1);
      #1 reset = 1;
      #1;
      check("mid_rst_ready", 32'(bus.iomem_ready), 0);
      check("mid_rst_gpio_out", 32'(gpio_out), 0);
      bus.iomem_valid = 0;
      @(posedge clk);
      #1 reset = 0;
      model_reset();
      rd(OFF_GPIO_OUT, "post_rst_out");

      // Out-of-window access stays silent
      sync_edge();
      bus.iomem_addr = 32'h0400_0000; bus.iomem_wstrb = 0; bus.iomem_valid = 1;
      cnt = 0; bad = 0;
      repeat (10) begin
         sync_edge();
         if (bus.iomem_ready) cnt++;
         if (bus.iomem_rdata !== 32'd0) bad++;
      end
      bus.iomem_valid = 0;
      check("oow_ready", cnt, 0);
      check("oow_rdata", bad, 0);
      rd(8'h40, "unmapped_40");

      // GPIO_IN synchronizer latency
      sync_edge();
      gin_old = gin_new; gin_new = 32'h1234; gin_edge = cyc; gpio_in = 16'h1234;
      rd(OFF_GPIO_IN, "gin_early");
      rd(OFF_GPIO_IN, "gin_late");

      // Randomized register traffic, timer left disabled
      for (int it = 0; it < 80; it++) begin
         s = 4'($urandom);
         d = $urandom;
         case ($urandom_range(0, 6))
            0: wr(OFF_GPIO_OUT, s, d, "rnd_wr_out", c);
            1: wr(OFF_GPIO_OE, s, d, "rnd_wr_oe", c);
            2: wr($urandom_range(0, 1) ? OFF_LOAD : OFF_COUNT, s, d, "rnd_wr_tmr", c);
            3: wr(OFF_CTRL, s, d & ~32'h1, "rnd_wr_ctrl", c);
            4, 5: begin
               o = roffs[$urandom_range(0, 9)];
               rd(o, "rnd_rd");
            end
            default: begin
               if ($urandom_range(0, 1) == 1) begin
                  sync_edge();
                  gin_old = gin_new; gin_new = d & GMASK; gin_edge = cyc;
                  gpio_in = GW'(d);
               end else begin
                  wr($urandom_range(0, 1) ? 8'h1C : 8'h80, s, d, "rnd_wr_unmapped", c);
               end
            end
         endcase
      end
      sync_edge();
      check("rnd_gpio_out_pin", 32'(gpio_out), m_out);
      check("rnd_gpio_oe_pin", 32'(gpio_oe), m_oe);
      foreach (offs[i]) rd(offs[i], "rnd_final_rd");

      // Auto-reload timer with interrupt
      wr(OFF_CTRL, 4'hF, 32'h0, "tmr_off", c);
      wr(OFF_LOAD, 4'hF, 32'd3, "tmr_load", c);
      wr(OFF_COUNT, 4'hF, 32'd3, "tmr_count", c);
      wr(OFF_CTRL, 4'b0001, 32'h7, "tmr_ctrl_auto", e_t);
      go_to(e_t + 4);
      check("irq_pre", 32'(irq), 0);
      go_to(e_t + 5);
      check("irq_rise", 32'(irq), 1);
      for (int i = 0; i < 5; i++) begin
         sync_edge();
         repeat ($urandom_range(0, 3)) sync_edge();
         n = cyc;
         xfer(BASE | 32'(OFF_COUNT), 0, 0, 32'(tf(n - e_t, 3, 3)), 1, "cnt_auto", c);
      end
      sync_edge();
      xfer(BASE | 32'(OFF_STATUS), 0, 0, 32'd1, 1, "status_set", c);
      wr(OFF_CTRL, 4'b0001, 32'h4, "tmr_stop", d_t);
      hold = tf(d_t - e_t, 3, 3);
      m_count = hold;
      m_exp = 1;
      sync_edge();
      check("irq_hold", 32'(irq), 1);
      rd(OFF_COUNT, "cnt_stopped");
      wr(OFF_STATUS, 4'b0001, 32'h1, "w1c", w_t);
      sync_edge();
      check("irq_clr", 32'(irq), 0);
      rd(OFF_STATUS, "status_clr");

      // One-shot: EN clears after expiry
      wr(OFF_COUNT, 4'hF, 32'd2, "os_count", c);
      wr(OFF_CTRL, 4'b0001, 32'h5, "os_ctrl", e_t);
      go_to(e_t + 3);
      check("os_irq_pre", 32'(irq), 0);
      go_to(e_t + 4);
      check("os_irq_rise", 32'(irq), 1);
      m_ctrl = 3'h4; m_count = 0; m_exp = 1;
      rd(OFF_CTRL, "os_en_clr");
      rd(OFF_COUNT, "os_count0");
      rd(OFF_STATUS, "os_status");
      wr(OFF_STATUS, 4'b0001, 32'h1, "os_w1c", c);
      wr(OFF_CTRL, 4'b0001, 32'h0, "os_off", c);

      // W1C in the same cycle as expiry loses
      wr(OFF_COUNT, 4'hF, 32'd5, "col_count", c);
      wr(OFF_CTRL, 4'b0001, 32'h1, "col_ctrl", e_t);
      go_to(e_t + 5);
      xfer(BASE | 32'(OFF_STATUS), 4'b0001, 32'h1, 0, 0, "col_w1c", c);
      check("col_commit_edge", c, e_t + 6);
      m_exp = 1; m_ctrl = 0; m_count = 0;
      rd(OFF_STATUS, "col_status");
      rd(OFF_CTRL, "col_en_clr");
      wr(OFF_STATUS, 4'b0001, 32'h1, "col_clr", c);
      rd(OFF_STATUS, "col_status_clr");

      // COUNT write beats a concurrent decrement
      wr(OFF_COUNT, 4'hF, 32'd50, "cw_count", c);
      wr(OFF_CTRL, 4'b0001, 32'h1, "cw_ctrl", e_t);
      go_to(e_t + 5);
      xfer(BASE | 32'(OFF_COUNT), 4'hF, 32'd10, 0, 0, "cw_wr10", x_t);
      sync_edge();
      n = cyc;
      xfer(BASE | 32'(OFF_COUNT), 0, 0, 32'(10 - (n - x_t)), 1, "cw_running", c);
      wr(OFF_CTRL, 4'b0001, 32'h0, "cw_stop", d_t);
      m_count = 32'(10 - (d_t - x_t));
      rd(OFF_COUNT, "cw_hold");

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      check("sb_drain", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iomem_gpio_timer.md
Name: iomem_gpio_timer

Overview:
- Memory-mapped peripheral on the picosoc iomem bus, placed on-chip between the core's iomem port and the iomem pad ring.
- Decodes one address window and provides a GPIO bank plus a 32-bit down-counting timer.
- Drives a level interrupt to the core's irq_5 input.
- Outside its window it stays silent, so other iomem slaves can respond.

Parameters:
- BASE_ADDR, 32'h0300_0000, window base; match on iomem_addr[31:8] == BASE_ADDR[31:8].
- GPIO_W, 16, GPIO bank width (1..32).
- SYNC_STAGES, 2, synchronizer depth on gpio_in (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- iomem_valid  input  1  core request valid; held until ready.
- iomem_ready  output  1  one-cycle acknowledge.
- iomem_wstrb  input  4  byte write strobes; 0 = read.
- iomem_addr  input  32  byte address.
- iomem_wdata  input  32  write data.
- iomem_rdata  output  32  read data, valid while iomem_ready=1.
- gpio_in  input  GPIO_W  asynchronous pad inputs.
- gpio_out  output  GPIO_W  output register.
- gpio_oe  output  GPIO_W  output enables.
- timer_irq  output  1  level interrupt, goes to irq_5.

Behaviour:
- Reset (async assert, sync release): iomem_ready=0, iomem_rdata=0, gpio_out=0, gpio_oe=0, timer_irq=0; all registers and sync flops cleared.
- Register map (offset = addr[7:0]):
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_OE, RW.
  - 0x08 GPIO_IN, RO; synchronized value.
  - 0x0C CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x10 LOAD, RW.
  - 0x14 COUNT, RW; a write loads the counter.
  - 0x18 STATUS: bit0 EXPIRED, write-1-to-clear.
  - Any other in-window offset: acknowledged, reads 0, writes ignored.
- Handshake: accept a request when iomem_valid=1, the address is in window and iomem_ready=0. iomem_ready goes to 1 in the next cycle for exactly one cycle, with iomem_rdata registered alongside it.
- Write side effects commit on the same edge that raises iomem_ready.
- After the ready pulse, iomem_ready is 0 for at least one cycle, so a held valid is never double-acknowledged.
- Out-of-window requests: iomem_ready stays 0; iomem_rdata is held at 0.
- Byte strobes apply per byte to RW registers. Bits above GPIO_W are ignored on write and read as 0.
- Timer:
  - While EN=1 and COUNT!=0: COUNT decrements by 1 each cycle.
  - While EN=1 and COUNT==0: set EXPIRED. If AUTO_RELOAD=1, COUNT<=LOAD; otherwise EN<=0.
  - While EN=0: COUNT holds.
- Simultaneous events:
  - A bus write to COUNT beats a decrement or reload in the same cycle.
  - A bus write to CTRL beats the auto-clear of EN.
  - Hardware setting EXPIRED beats a W1C in the same cycle.
- timer_irq is registered: timer_irq <= EXPIRED & IRQ_EN, i.e. one cycle after EXPIRED sets.
- GPIO_IN: SYNC_STAGES-flop chain per bit. A read returns the last synchronizer stage.
- Reset mid-transaction: ready drops immediately. The core restarts its access after reset, so no pending state is kept.

Decomposition:
- Shared package iomem_pkg:
  - register offset constants (OFF_GPIO_OUT ... OFF_STATUS);
  - CTRL bit-index constants;
  - default window base constant.
- One sub-module, sync_ff: a parameterised-width, SYNC_STAGES-deep synchronizer with the same clk/reset, instantiated for gpio_in.
- Bus decode, register file and timer stay in the top module.

Test Plan:
- Reset with all inputs toggling -> every output 0; a read of each mapped register returns 0.
- Write 0x0000_A5A5 to 0x0300_0000 with wstrb=4'b0001, then read -> rdata=0x0000_00A5, gpio_out=0x00A5. Ready pulses exactly one cycle after valid; valid held 3 cycles yields only one ready.
- Read of 0x0400_0000 with valid held 10 cycles -> ready never asserts. Read of offset 0x40 -> ready after 1 cycle, rdata=0.
- gpio_in changes to 0x1234 -> read of GPIO_IN returns 0x1234 no earlier than 2 cycles after the change; an earlier read returns the old value.
- LOAD=3, COUNT=3, CTRL=0x7 -> COUNT goes 3,2,1,0 then reloads to 3; EXPIRED sets and timer_irq rises one cycle later. A W1C to STATUS clears the irq; with AUTO_RELOAD=0, EN clears after expiry.
- W1C to STATUS in the same cycle EXPIRED sets -> EXPIRED stays 1. COUNT write of 10 in the same cycle as a decrement -> COUNT=10.
